pbs_ctrl: RTL and testbench
===========================

// Module: pbs_ctrl
// PURPOSE
//  Battle-turn controller directly upstream of the battle datapath. Sequences one player
//  attack then one AI attack per turn, drives the datapath strobes (actr, target, stop,
//  load_ai_hp, app_ai_dmg, app_pl_dmg), resolves hit/miss from the accuracy RNG, detects KO.
//  The datapath does not saturate HP, so KO is decided here before damage is applied.
// PARAMETERS
//  AI_DELAY   4   cycles in AI_WAIT before the AI move is locked (>=1)
//  MAX_TURNS  8   full turns before a draw (used only with PBS_TURN_LIMIT_EN)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst         in   1  asynchronous, active-low reset
//  go          in   1  player confirm button; rising edge starts a turn
//  p_hp        in   4  player HP from datapath
//  ai_hp       in   4  AI HP from datapath
//  dmg         in   4  damage of the currently selected move, from datapath
//  accu        in   4  accuracy of the currently selected move, from datapath
//  acc_rng     in   4  accuracy random value from the shared GARO bank
//  actr        out  1  0 = player move selected, 1 = AI random move
//  target      out  1  1 = AI is defender, 0 = player is defender
//  stop        out  1  freezes GARO RNGs while a move/accuracy is sampled
//  load_ai_hp  out  1  one-cycle pulse: datapath snapshots AI HP
//  app_ai_dmg  out  1  one-cycle pulse: write damaged AI HP
//  app_pl_dmg  out  1  one-cycle pulse: write damaged player HP
//  hit         out  1  result of most recent accuracy check (registered)
//  game_over   out  1  high in DONE
//  winner      out  1  valid with game_over: 0 player, 1 AI
//  draw        out  1  turn limit reached (tied 0 without PBS_TURN_LIMIT_EN)
//  state       out  4  current state encoding, debug
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, all outputs 0, go edge register=0, counters=0, ko=0.
//  Outputs are Moore-decoded from the state register; hit/winner/draw are registers.
//  States (encoding) / outputs / transition:
//   0 IDLE    actr=0; rising edge of go -> P_SET. Level-high go does not retrigger.
//   1 P_SET   actr=0 target=1; 1 cycle for datapath move mux to register -> P_LOAD
//   2 P_LOAD  load_ai_hp=1 stop=1 -> P_CHK
//   3 P_CHK   stop=1; hit<=(acc_rng<=accu); ko<=hit_new&&(dmg>=ai_hp) -> P_APP
//   4 P_APP   app_ai_dmg=hit (no pulse on miss) -> P_POST
//   5 P_POST  ko: winner<=0 -> DONE; else cnt<=AI_DELAY-1 -> AI_WAIT
//   6 AI_WAIT actr=1 target=0; cnt-- each cycle; cnt==0 -> AI_SET
//   7 AI_SET  actr=1 stop=1 (AI move frozen, datapath registers it) -> AI_CHK
//   8 AI_CHK  actr=1 stop=1; hit<=(acc_rng<=accu); ko<=hit_new&&(dmg>=p_hp) -> AI_APP
//   9 AI_APP  actr=1 app_pl_dmg=hit -> AI_POST
//  10 AI_POST ko: winner<=1 -> DONE; else turn++ -> IDLE
//  11 DONE    game_over=1; terminal, go ignored; exit only via rst. Unused codes -> IDLE.
//  - go edges outside IDLE are ignored (not queued).
//  - accu=15 always hits; acc_rng=15 with accu<15 misses.
//  - dmg=0 hit: pulse issued, HP unchanged, no KO. Exact kill (dmg==hp) is a KO.
//  - At most one of load_ai_hp/app_ai_dmg/app_pl_dmg high in any cycle.
//  - Turn latency go-edge to IDLE: 10 + AI_DELAY cycles.
//  - rst low mid-turn: immediate return to IDLE, all pulses drop same instant.
// CONFIGURATION
//  PBS_TURN_LIMIT_EN defined: 4-bit turn counter; AI_POST with !ko and turn==MAX_TURNS-1
//   -> DONE with draw=1, winner=0. Undefined: no counter, draw tied 0, turns unbounded.
// TESTING
//  1 Reset: rst=0 mid AI_WAIT -> state=0, all outputs 0 asynchronously.
//  2 Player hit: ai_hp=15,dmg=4,accu=10,acc_rng=3, go edge -> app_ai_dmg 1 pulse 4 cycles
//    after P_SET entry; hit=1; then AI_WAIT for 4 cycles.
//  3 Player miss: accu=2,acc_rng=9 -> hit=0, no app_ai_dmg pulse, flow continues to AI.
//  4 KO: ai_hp=3,dmg=3,hit -> DONE, game_over=1, winner=0; later go edges ignored.
//  5 AI KO: p_hp=2,dmg=5,accu=15 in AI_CHK -> app_pl_dmg pulse, DONE, winner=1.
//  6 go held high 30 cycles -> exactly one turn; with PBS_TURN_LIMIT_EN, MAX_TURNS=2,
//    all misses -> DONE after 2nd AI_POST, draw=1.

Source files
------------

// File: rtl/pbs_ctrl.sv
// pbs_ctrl: battle-turn sequencer (player attack then AI attack), hit/miss and KO resolution.
// Optional feature: define PBS_TURN_LIMIT_EN to end the game in a draw after MAX_TURNS turns.
module pbs_ctrl #(
    parameter int AI_DELAY  = 4,
    parameter int MAX_TURNS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] p_hp,
    input  logic [3:0] ai_hp,
    input  logic [3:0] dmg,
    input  logic [3:0] accu,
    input  logic [3:0] acc_rng,
    output logic       actr,
    output logic       target,
    output logic       stop,
    output logic       load_ai_hp,
    output logic       app_ai_dmg,
    output logic       app_pl_dmg,
    output logic       hit,
    output logic       game_over,
    output logic       winner,
    output logic       draw,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        P_SET   = 4'd1,
        P_LOAD  = 4'd2,
        P_CHK   = 4'd3,
        P_APP   = 4'd4,
        P_POST  = 4'd5,
        AI_WAIT = 4'd6,
        AI_SET  = 4'd7,
        AI_CHK  = 4'd8,
        AI_APP  = 4'd9,
        AI_POST = 4'd10,
        DONE    = 4'd11
    } st_t;

    localparam int CW = $clog2(AI_DELAY + 1);

    st_t         cur, nxt;
    logic [CW-1:0] cnt;
    logic        go_q, ko, hit_new, last_turn;

    // the datapath does not saturate HP, so a KO must be caught before damage is written
    assign hit_new = acc_rng <= accu;

`ifdef PBS_TURN_LIMIT_EN
    logic [3:0] turn;

    assign last_turn = turn == 4'(MAX_TURNS - 1);

    // count completed turns; the last one ends the game as a draw
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            turn <= 4'd0;
            draw <= 1'b0;
        end else if (cur == AI_POST && !ko) begin
            turn <= turn + 4'd1;
            draw <= last_turn;
        end
`else
    assign last_turn = 1'b0;
    assign draw      = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) cur <= IDLE;
        else      cur <= nxt;

    // next state and Moore-decoded strobes
    always_comb begin
        nxt        = IDLE;
        state      = cur;
        actr       = cur >= AI_WAIT && cur <= AI_APP;
        target     = cur >= P_SET && cur <= P_POST;
        stop       = cur == P_LOAD || cur == P_CHK || cur == AI_SET || cur == AI_CHK;
        load_ai_hp = cur == P_LOAD;
        app_ai_dmg = cur == P_APP && hit;
        app_pl_dmg = cur == AI_APP && hit;
        game_over  = cur == DONE;
        case (cur)
            IDLE:    nxt = (go && !go_q) ? P_SET : IDLE;
            P_SET:   nxt = P_LOAD;
            P_LOAD:  nxt = P_CHK;
            P_CHK:   nxt = P_APP;
            P_APP:   nxt = P_POST;
            P_POST:  nxt = ko ? DONE : AI_WAIT;
            AI_WAIT: nxt = cnt == '0 ? AI_SET : AI_WAIT;
            AI_SET:  nxt = AI_CHK;
            AI_CHK:  nxt = AI_APP;
            AI_APP:  nxt = AI_POST;
            AI_POST: nxt = (ko || last_turn) ? DONE : IDLE;
            DONE:    nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    // go edge detect, accuracy/KO result, winner and AI think-time counter
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            go_q   <= 1'b0;
            hit    <= 1'b0;
            ko     <= 1'b0;
            winner <= 1'b0;
            cnt    <= '0;
        end else begin
            go_q <= go;
            if (cur == P_CHK || cur == AI_CHK) begin
                hit <= hit_new;
                ko  <= hit_new && (dmg >= (cur == P_CHK ? ai_hp : p_hp));
            end
            if (cur == P_POST && ko) winner <= 1'b0;
            if (cur == AI_POST && ko) winner <= 1'b1;
            if (cur == P_POST) cnt <= CW'(AI_DELAY - 1);
            else if (cur == AI_WAIT) cnt <= cnt - 1'b1;
        end

endmodule

// File: tb/tb_pbs_ctrl.sv
// tb_pbs_ctrl: per-cycle model check of pbs_ctrl turns, KO, reset and go handling.
module tb_pbs_ctrl;
`ifdef PBS_TURN_LIMIT_EN
    localparam int MT = 2;
`else
    localparam int MT = 8;
`endif
    localparam int AD = 4;

    logic       clk = 0, rst = 0, go = 0;
    logic [3:0] p_hp = 15, ai_hp = 15, dmg = 0, accu = 0, acc_rng = 0;
    logic       actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg;
    logic       hit, game_over, winner, draw;
    logic [3:0] state;

    pbs_ctrl #(.AI_DELAY(AD), .MAX_TURNS(MT)) dut (
        .clk(clk), .rst(rst), .go(go), .p_hp(p_hp), .ai_hp(ai_hp), .dmg(dmg),
        .accu(accu), .acc_rng(acc_rng), .actr(actr), .target(target), .stop(stop),
        .load_ai_hp(load_ai_hp), .app_ai_dmg(app_ai_dmg), .app_pl_dmg(app_pl_dmg),
        .hit(hit), .game_over(game_over), .winner(winner), .draw(draw), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       hit, win, drw, ld, aa, ap;
    } rec_t;

    rec_t q[$];
    logic m_hit = 0, m_win = 0, m_drw = 0, m_done = 0;
    int   m_turn = 0;
    int   n_chk = 0, n_fail = 0;

    task automatic push(input logic [3:0] s, input logic ld, input logic aa, input logic ap);
        rec_t r;
        r = '{st: s, hit: m_hit, win: m_win, drw: m_drw, ld: ld, aa: aa, ap: ap};
        q.push_back(r);
    endtask

    task automatic model_clear();
        q.delete();
        m_hit = 0; m_win = 0; m_drw = 0; m_done = 0; m_turn = 0;
    endtask

    // expected per-cycle trace of one whole turn, from the rules of the game
    task automatic push_turn();
        logic hp, kp, ha, ka;
        hp = acc_rng <= accu;
        kp = hp && dmg >= ai_hp;
        ha = acc_rng <= accu;
        ka = ha && dmg >= p_hp;
        push(4'd1, 0, 0, 0);
        push(4'd2, 1, 0, 0);
        push(4'd3, 0, 0, 0);
        m_hit = hp;
        push(4'd4, 0, hp, 0);
        push(4'd5, 0, 0, 0);
        if (kp) begin m_done = 1; m_win = 0; return; end
        for (int i = 0; i < AD; i++) push(4'd6, 0, 0, 0);
        push(4'd7, 0, 0, 0);
        push(4'd8, 0, 0, 0);
        m_hit = ha;
        push(4'd9, 0, 0, ha);
        push(4'd10, 0, 0, 0);
        if (ka) begin m_done = 1; m_win = 1; return; end
`ifdef PBS_TURN_LIMIT_EN
        if (m_turn == MT - 1) begin m_done = 1; m_drw = 1; m_win = 0; return; end
`endif
        m_turn++;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // compare DUT against the model every cycle while out of reset
    always @(negedge clk) begin
        rec_t e;
        logic [10:0] ev, av;
        if (rst) begin
            if (q.size() > 0) e = q.pop_front();
            else e = '{st: (m_done ? 4'd11 : 4'd0), hit: m_hit, win: m_win, drw: m_drw, ld: 0, aa: 0, ap: 0};
            ev = {e.st, e.hit, e.win, e.drw, e.ld, e.aa, e.ap,
                  (e.st == 2 || e.st == 3 || e.st == 7 || e.st == 8)};
            av = {state, hit, winner, draw, load_ai_hp, app_ai_dmg, app_pl_dmg, stop};
            n_chk++;
            if (av !== ev || game_over !== (e.st == 11)) begin
                n_fail++;
                $display("FAIL cycle_cmp at %0t: got {st,hit,win,drw,ld,aa,ap,stop}=%h go=%b expected %h go=%b",
                         $time, av, game_over, ev, e.st == 11);
            end
            if (e.st <= 3 || (e.st >= 6 && e.st <= 9)) begin
                n_chk++;
                if (actr !== (e.st >= 6)) begin
                    n_fail++;
                    $display("FAIL actr at %0t st=%0d: got %b expected %b", $time, e.st, actr, e.st >= 6);
                end
            end
            if (e.st == 1 || e.st == 6) begin
                n_chk++;
                if (target !== (e.st == 1)) begin
                    n_fail++;
                    $display("FAIL target at %0t st=%0d: got %b expected %b", $time, e.st, target, e.st == 1);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0; go = 0;
        model_clear();
        @(negedge clk);
        #1 rst = 1;
    endtask

    // start a turn; go high for cycles < hold plus one extra pulse at cycle 'extra'
    task automatic turn(input int hold, input int extra, output int t_aa, output int t_ap,
                        output int t_end, output int n_wait);
        t_aa = -1; t_ap = -1; t_end = -1; n_wait = 0;
        go = 1;
        push_turn();
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            #1 go = (c < hold) || (c == extra);
            if (t_aa < 0 && app_ai_dmg) t_aa = c;
            if (t_ap < 0 && app_pl_dmg) t_ap = c;
            if (state == 4'd6) n_wait++;
            if (t_end < 0 && c > 1 && (state == 4'd0 || state == 4'd11)) t_end = c;
        end
    endtask

    int ta, tp, te, nw;

    initial begin
        #1;
        chk("rst_state", state, 0);
        chk("rst_outs", {actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg, hit, game_over, winner, draw}, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1;

        ai_hp = 15; p_hp = 15; dmg = 4; accu = 10; acc_rng = 3;
        turn(1, -1, ta, tp, te, nw);
        chk("hit_app_latency", ta, 4);
        chk("hit_turn_latency", te, 14);
        chk("hit_wait_cycles", nw, AD);
        chk("hit_flag", hit, 1);

        do_reset();
        turn(30, -1, ta, tp, te, nw);
        chk("held_go_latency", te, 14);
        chk("held_go_one_turn", state, 0);

        do_reset();
        accu = 2; acc_rng = 9;
        turn(1, 6, ta, tp, te, nw);
        chk("miss_no_app", ta, -1);
        chk("miss_hit", hit, 0);
        chk("miss_latency", te, 14);

        do_reset();
        accu = 15; acc_rng = 15; dmg = 0; ai_hp = 5; p_hp = 5;
        turn(1, -1, ta, tp, te, nw);
        chk("acc15_app", ta, 4);
        chk("dmg0_pl_app", tp, 12);
        chk("dmg0_no_ko", game_over, 0);

        do_reset();
        accu = 14; acc_rng = 15; dmg = 4;
        turn(1, -1, ta, tp, te, nw);
        chk("rng15_miss", ta, -1);
        chk("rng15_hit", hit, 0);

        do_reset();
        accu = 10; acc_rng = 3; ai_hp = 15; p_hp = 15;
        go = 1;
        push_turn();
        @(negedge clk);
        #1 go = 0;
        repeat (5) @(negedge clk);
        #1 chk("pre_rst_ai_wait", state, 6);
        #1 rst = 0;
        model_clear();
        #1 chk("async_rst_state", state, 0);
        chk("async_rst_outs", {actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg, hit, game_over, winner, draw}, 0);
        @(negedge clk);
        #1 rst = 1;

        p_hp = 2; ai_hp = 15; dmg = 5; accu = 15; acc_rng = 0;
        turn(1, -1, ta, tp, te, nw);
        chk("ai_ko_app", tp, 12);
        chk("ai_ko_done", te, 14);
        chk("ai_ko_winner", winner, 1);
        chk("ai_ko_game_over", game_over, 1);

        do_reset();
        p_hp = 15; ai_hp = 3; dmg = 3; accu = 10; acc_rng = 3;
        turn(1, -1, ta, tp, te, nw);
        chk("pl_ko_done", te, 6);
        chk("pl_ko_winner", winner, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 go = 1;
            @(negedge clk);
            #1 go = 0;
            @(negedge clk);
            #1 chk("done_ignores_go", state, 11);
        end

`ifdef PBS_TURN_LIMIT_EN
        do_reset();
        ai_hp = 15; p_hp = 15; dmg = 4; accu = 2; acc_rng = 9;
        turn(1, -1, ta, tp, te, nw);
        chk("draw_turn1_idle", state, 0);
        turn(1, -1, ta, tp, te, nw);
        chk("draw_flag", draw, 1);
        chk("draw_game_over", game_over, 1);
        chk("draw_winner", winner, 0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
